uart_seq: RTL and testbench

UART_SEQ -- requirements
Module: uart_seq

---
 rtl/uart_seq.sv | 110 +++++++++++
 tb/tb_uart_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_seq.sv
// Byte-stream front end for a register-mapped UART: polls status, drains RX bytes
// into a small FIFO and forwards TX bytes, one register access per cycle.
//
// state | meaning
// POLL  | read status register (u_addr=1)
// STAT  | status from POLL is on u_dbr; choose RX service, TX write or re-poll
// RDDAT | read data register (u_addr=0)
// RDCAP | data byte is on u_dbr; push it into the RX FIFO
// ACK   | write status register to clear the UART RX flag
// WR    | write tx_data to the data register; tx_data accepted
module uart_seq #(
  parameter int RXQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_stall,
  input  logic [7:0] u_dbr,
  output logic [7:0] u_dbw,
  output logic       u_addr,
  output logic       u_we
);

  localparam int PW = $clog2(RXQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {POLL, STAT, RDDAT, RDCAP, ACK, WR} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [RXQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, pop;

  assign full     = (count == CW'(RXQ_DEPTH));
  assign push     = (state == RDCAP);
  assign pop      = rx_valid && rx_ready;
  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) state <= POLL;
    else     state <= state_nxt;
  end

  // Stall flag is only re-evaluated when a fresh status byte is examined.
  always_ff @(posedge clk) begin
    if (rst)                rx_stall <= 1'b0;
    else if (state == STAT) rx_stall <= u_dbr[6] && full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // STAT never selects RDDAT when full, so a push always has room.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= u_dbr;
  end

  always_comb begin
    state_nxt = state;
    u_addr    = 1'b1;
    u_we      = 1'b0;
    u_dbw     = 8'h00;
    tx_ready  = 1'b0;
    case (state)
      POLL: state_nxt = STAT;
      STAT: begin
        if (u_dbr[6] && !full)       state_nxt = RDDAT;
        else if (!u_dbr[7] && tx_valid) state_nxt = WR;
        else                         state_nxt = POLL;
      end
      RDDAT: begin
        u_addr    = 1'b0;
        state_nxt = RDCAP;
      end
      RDCAP: begin
        u_addr    = 1'b0;
        state_nxt = ACK;
      end
      ACK: begin
        u_we      = 1'b1;
        state_nxt = POLL;
      end
      WR: begin
        u_addr    = 1'b0;
        u_we      = 1'b1;
        u_dbw     = tx_data;
        tx_ready  = 1'b1;
        state_nxt = POLL;
      end
      default: state_nxt = POLL;
    endcase
  end

endmodule

// File: tb/tb_uart_seq.sv
// Bench for uart_seq: a behavioural UART register model, a bus-access plan predicted
// from each status read, byte scoreboards for both directions, directed and random runs.
module tb_uart_seq;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       rx_stall;
  logic [7:0] u_dbr = 8'h00;
  logic [7:0] u_dbw;
  logic       u_addr;
  logic       u_we;

  uart_seq #(.RXQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_stall(rx_stall),
    .u_dbr(u_dbr), .u_dbw(u_dbw), .u_addr(u_addr), .u_we(u_we)
  );

  always #5 clk = ~clk;

  // UART register file: reads are registered one cycle after being addressed.
  logic       uart_tx_full = 1'b0;
  logic       uart_rx_avail = 1'b0;
  logic [7:0] uart_rx_byte = 8'h00;
  logic [5:0] uart_junk = 6'h00;

  always @(posedge clk)
    if (u_we === 1'b0) u_dbr <= u_addr ? {uart_tx_full, uart_rx_avail, uart_junk} : uart_rx_byte;

  typedef enum {OP_POLL, OP_STAT, OP_RD, OP_CAP, OP_ACK, OP_WR} op_t;

  op_t         plan[$];
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          model_ok = 0, rst_last = 0, exp_stall = 0;
  bit          ack_seen = 0, wr_seen = 0, rand_mode = 0;
  int          n_checks = 0, n_fail = 0;
  int          n_wr = 0, n_rd0 = 0, n_acc = 0, n_pop = 0;
  int          busy = 0, rx_left = 0, tx_left = 0;
  int unsigned rdy_pct = 50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] bus_of(op_t o);  // {u_we, u_addr}
    case (o)
      OP_RD, OP_CAP: return 2'b00;
      OP_ACK:        return 2'b11;
      OP_WR:         return 2'b10;
      default:       return 2'b01;
    endcase
  endfunction

  task automatic drive_tx();
    tx_valid = (txq.size() != 0);
    if (txq.size() != 0) tx_data = txq[0];
  endtask

  // Runs just before each rising edge: checks this cycle's outputs, applies the edge's effects.
  task automatic model_edge();
    op_t        cur;
    logic [7:0] stat;
    int         sz;
    if (rst_last) begin
      check("rst_we", 32'(u_we), 0);
      check("rst_addr", 32'(u_addr), 1);
      check("rst_dbw", 32'(u_dbw), 0);
      check("rst_tx_ready", 32'(tx_ready), 0);
      check("rst_rx_valid", 32'(rx_valid), 0);
      check("rst_rx_stall", 32'(rx_stall), 0);
    end
    if (model_ok) begin
      cur = plan.pop_front();
      check("bus", 32'({u_we, u_addr}), 32'(bus_of(cur)));
      check("tx_ready", 32'(tx_ready), 32'(cur == OP_WR));
      check("rx_valid", 32'(rx_valid), 32'(rxq.size() != 0));
      check("rx_stall", 32'(rx_stall), 32'(exp_stall));
      if (!u_we && !u_addr) n_rd0++;
      if (u_we && !u_addr) begin n_wr++; wr_seen = 1; end
      if (u_we && u_addr) ack_seen = 1;
      sz = rxq.size();
      if (cur == OP_STAT) begin
        stat = u_dbr;
        exp_stall = stat[6] && (sz >= DEPTH);
        if (stat[6] && sz < DEPTH) begin
          plan.push_back(OP_RD); plan.push_back(OP_CAP); plan.push_back(OP_ACK);
        end else if (!stat[7] && tx_valid) plan.push_back(OP_WR);
      end
      if (cur == OP_WR) begin
        check("tx_pending", 32'(txq.size() != 0), 1);
        if (txq.size() != 0) begin
          check("tx_byte", 32'(u_dbw), 32'(txq[0]));
          void'(txq.pop_front());
          n_acc++;
        end
      end else if (cur == OP_POLL || cur == OP_ACK) check("dbw_idle", 32'(u_dbw), 0);
      if (rx_valid && rx_ready && sz != 0) begin
        check("rx_data", 32'(rx_data), 32'(rxq[0]));
        void'(rxq.pop_front());
        n_pop++;
      end
      if (cur == OP_CAP) rxq.push_back(uart_rx_byte);
      if (plan.size() == 0) begin plan.push_back(OP_POLL); plan.push_back(OP_STAT); end
    end
    if (rst) begin
      rxq.delete(); plan.delete();
      plan.push_back(OP_POLL); plan.push_back(OP_STAT);
      exp_stall = 0; model_ok = 1;
    end
    rst_last = rst;
  endtask

  task automatic post_edge();
    if (ack_seen) uart_rx_avail = 1'b0;
    uart_junk = 6'($urandom);
    if (rand_mode) begin
      if (busy > 0) busy--;
      if (wr_seen) busy = int'($urandom_range(0, 4));
      uart_tx_full = (busy > 0);
      if (!uart_rx_avail && rx_left > 0 && $urandom_range(0, 3) == 0) begin
        uart_rx_byte = 8'($urandom); uart_rx_avail = 1'b1; rx_left--;
      end
      if (txq.size() == 0 && tx_left > 0 && $urandom_range(0, 2) == 0) begin
        txq.push_back(8'($urandom)); tx_left--;
      end
      rx_ready = ($urandom_range(0, 99) < rdy_pct);
    end
    ack_seen = 0; wr_seen = 0;
    drive_tx();
  endtask

  // Returns at the falling edge of the next cycle, outputs settled for sampling.
  task automatic tick();
    #1 model_edge();
    @(posedge clk);
    #1 post_edge();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    txq.delete(); drive_tx();
    uart_tx_full = 1'b0; uart_rx_avail = 1'b0; rx_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic feed_rx(input logic [7:0] b);
    uart_rx_byte = b; uart_rx_avail = 1'b1;
    for (int i = 0; i < 20 && uart_rx_avail; i++) tick();
    check("feed_acked", 32'(uart_rx_avail), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, ack_idx, wr_idx, base, cyc;
    bit done;

    // TX single
    reset_dut();
    txq.push_back(8'h5A); drive_tx();
    base = n_wr; first = -1; cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_ready) begin
        cnt++;
        if (first < 0) begin
          first = i;
          check("tx1_we", 32'(u_we), 1);
          check("tx1_addr", 32'(u_addr), 0);
          check("tx1_dbw", 32'(u_dbw), 32'h5A);
        end
      end
    end
    check("tx1_cycles", 32'(cnt), 1);
    check("tx1_when", 32'(first), 1);
    check("tx1_writes", 32'(n_wr - base), 1);

    // RX single
    reset_dut();
    uart_rx_byte = 8'hC3; uart_rx_avail = 1'b1;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rx_valid && first < 0) begin
        first = i;
        check("rx1_data", 32'(rx_data), 32'hC3);
        check("rx1_ack", 32'({u_we, u_addr}), 32'b11);
      end
    end
    check("rx1_when", 32'(first), 3);
    check("rx1_held", 32'(rx_valid), 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    check("rx1_empty", 32'(rx_valid), 0);

    // RX priority over pending TX
    reset_dut();
    uart_rx_byte = 8'h77; uart_rx_avail = 1'b1;
    txq.push_back(8'h11); drive_tx();
    ack_idx = -1; wr_idx = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (u_we && u_addr && ack_idx < 0) ack_idx = i;
      if (tx_ready && wr_idx < 0) wr_idx = i;
    end
    check("prio_ack", 32'(ack_idx), 3);
    check("prio_wr", 32'(wr_idx), 6);

    // Full FIFO stall, TX during stall, release and order
    reset_dut();
    for (int k = 1; k <= 4; k++) feed_rx(8'(k));
    uart_rx_byte = 8'h05; uart_rx_avail = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("stall_set", 32'(rx_stall), 1);
    base = n_rd0; cnt = n_wr;
    txq.push_back(8'hA5); drive_tx();
    for (int i = 0; i < 8; i++) tick();
    check("stall_no_rd", 32'(n_rd0 - base), 0);
    check("stall_tx", 32'(n_wr - cnt), 1);
    check("stall_hold", 32'(rx_stall), 1);
    check("stall_head", 32'(rx_data), 32'h01);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    for (int i = 0; i < 12 && uart_rx_avail; i++) tick();
    check("stall_drained", 32'(uart_rx_avail), 0);
    check("stall_clr", 32'(rx_stall), 0);
    for (int k = 2; k <= 5; k++) begin
      check("fifo_order", 32'(rx_data), 32'(k));
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    end
    check("fifo_empty", 32'(rx_valid), 0);

    // TX busy
    reset_dut();
    uart_tx_full = 1'b1;
    txq.push_back(8'h3C); drive_tx();
    base = n_rd0; cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (tx_ready) cnt++; end
    check("busy_no_ready", 32'(cnt), 0);
    check("busy_no_rd", 32'(n_rd0 - base), 0);
    uart_tx_full = 1'b0;
    for (int i = 0; i < 10 && txq.size() != 0; i++) tick();
    check("busy_sent", 32'(txq.size()), 0);

    // Reset during WR
    reset_dut();
    feed_rx(8'h42);
    txq.push_back(8'h99); drive_tx();
    for (int i = 0; i < 10 && !tx_ready; i++) tick();
    check("rstwr_reach", 32'(tx_ready), 1);
    rst = 1'b1;
    tick();
    check("rstwr_we", 32'(u_we), 0);
    check("rstwr_addr", 32'(u_addr), 1);
    check("rstwr_rx_valid", 32'(rx_valid), 0);
    rst = 1'b0;

    // Randomized traffic against the scoreboards
    reset_dut();
    rand_mode = 1; tx_left = 60; rx_left = 60;
    base = n_acc; cnt = n_pop; done = 0;
    for (cyc = 0; cyc < 20000 && !done; cyc++) begin
      if (cyc % 150 == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 5 : 90;
      tick();
      done = (tx_left == 0 && txq.size() == 0 && rx_left == 0 && !uart_rx_avail && rxq.size() == 0);
    end
    check("rand_done", 32'(done), 1);
    check("rand_tx_count", 32'(n_acc - base), 60);
    check("rand_rx_count", 32'(n_pop - cnt), 60);
    rand_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
